// File: rtl/mem_wb_pkg.sv
// Shared constants and helpers for the mem->wb pipeline register.
// Imported by mem_wb and hilo_reg.
package mem_wb_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int StallBus   = 6;

  localparam logic [RegBus-1:0]     ZeroWord     = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
  localparam logic                  WriteEnable  = 1'b1;
  localparam logic                  WriteDisable = 1'b0;
  localparam logic                  RstEnable    = 1'b0;

  localparam int StallMem = 4;
  localparam int StallWb  = 5;

  typedef enum logic [1:0] {
    WB_LOAD,
    WB_BUBBLE,
    WB_HOLD
  } wb_act_e;

  // Flush always wins; mem stalled with wb running drains wb with a bubble.
  function automatic wb_act_e wb_act(
    input logic                flush,
    input logic [StallBus-1:0] stall
  );
    wb_act_e a;
    a = WB_LOAD;
    unique case (1'b1)
      flush:
        a = WB_BUBBLE;
      !flush && stall[StallMem] && !stall[StallWb]:
        a = WB_BUBBLE;
      !flush && stall[StallMem] && stall[StallWb]:
        a = WB_HOLD;
      default:
        a = WB_LOAD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mem_wb_hilo_reg.sv
// Architectural HI/LO register pair.
// Written only when the wb stage commits a HI/LO write.
module hilo_reg
  import mem_wb_pkg::*;
#(
  parameter int W = RegBus
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  logic [W-1:0] hi_d, hi_q;
  logic [W-1:0] lo_d, lo_q;

  // Next HI/LO: take new values on write, otherwise hold.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (we) begin
      hi_d = hi_i;
      lo_d = lo_i;
    end
  end

  // HI/LO state with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mem_wb.sv
// mem->wb pipeline latch, commit logic and retire counter.
// Commits the wb instruction and owns the HI/LO registers.
module mem_wb
  import mem_wb_pkg::*;
#(
  parameter int REG_W  = RegBus,
  parameter int ADDR_W = RegAddrBus
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [StallBus-1:0] stall,
  input  logic                flush,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_wd,
  input  logic                mem_wreg,
  input  logic [REG_W-1:0]    mem_wdata,
  input  logic [REG_W-1:0]    mem_hi,
  input  logic [REG_W-1:0]    mem_lo,
  input  logic                mem_whilo,
  output logic [ADDR_W-1:0]   wb_wd,
  output logic                wb_wreg,
  output logic [REG_W-1:0]    wb_wdata,
  output logic [REG_W-1:0]    wb_hi,
  output logic [REG_W-1:0]    wb_lo,
  output logic                wb_whilo,
  output logic                wb_valid,
  output logic [REG_W-1:0]    hi_o,
  output logic [REG_W-1:0]    lo_o,
  output logic [31:0]         retire_cnt
);

  logic [ADDR_W-1:0] wb_wd_d, wb_wd_q;
  logic              wb_wreg_d, wb_wreg_q;
  logic [REG_W-1:0]  wb_wdata_d, wb_wdata_q;
  logic [REG_W-1:0]  wb_hi_d, wb_hi_q;
  logic [REG_W-1:0]  wb_lo_d, wb_lo_q;
  logic              wb_whilo_d, wb_whilo_q;
  logic              wb_valid_d, wb_valid_q;
  logic [31:0]       retire_cnt_d, retire_cnt_q;

  wb_act_e act;
  logic    commit;
  logic    hilo_we;

  // Low stall bits belong to earlier stages.
  logic unused_stall;
  assign unused_stall = ^stall[StallMem-1:0];

  // Next wb latch contents: load, bubble or hold.
  always_comb begin
    act        = wb_act(flush, stall);
    wb_wd_d    = wb_wd_q;
    wb_wreg_d  = wb_wreg_q;
    wb_wdata_d = wb_wdata_q;
    wb_hi_d    = wb_hi_q;
    wb_lo_d    = wb_lo_q;
    wb_whilo_d = wb_whilo_q;
    wb_valid_d = wb_valid_q;
    unique case (act)
      WB_LOAD: begin
        wb_wd_d    = mem_wd;
        wb_wreg_d  = mem_wreg;
        wb_wdata_d = mem_wdata;
        wb_hi_d    = mem_hi;
        wb_lo_d    = mem_lo;
        wb_whilo_d = mem_whilo;
        wb_valid_d = mem_valid;
      end
      WB_BUBBLE: begin
        wb_wd_d    = ADDR_W'(NOPRegAddr);
        wb_wreg_d  = WriteDisable;
        wb_wdata_d = REG_W'(ZeroWord);
        wb_hi_d    = REG_W'(ZeroWord);
        wb_lo_d    = REG_W'(ZeroWord);
        wb_whilo_d = WriteDisable;
        wb_valid_d = 1'b0;
      end
      WB_HOLD: begin
      end
      default: begin
      end
    endcase
  end

  // Commit: the wb instruction retires when wb is not stalled.
  always_comb begin
    commit       = wb_valid_q & ~stall[StallWb];
    hilo_we      = commit & (wb_whilo_q == WriteEnable);
    retire_cnt_d = retire_cnt_q + 32'(commit);
  end

  // wb latch and retire counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wb_wd_q      <= '0;
      wb_wreg_q    <= 1'b0;
      wb_wdata_q   <= '0;
      wb_hi_q      <= '0;
      wb_lo_q      <= '0;
      wb_whilo_q   <= 1'b0;
      wb_valid_q   <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      wb_wd_q      <= wb_wd_d;
      wb_wreg_q    <= wb_wreg_d;
      wb_wdata_q   <= wb_wdata_d;
      wb_hi_q      <= wb_hi_d;
      wb_lo_q      <= wb_lo_d;
      wb_whilo_q   <= wb_whilo_d;
      wb_valid_q   <= wb_valid_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  hilo_reg #(
    .W (REG_W)
  ) u_hilo (
    .clk  (clk),
    .rst  (rst),
    .we   (hilo_we),
    .hi_i (wb_hi_q),
    .lo_i (wb_lo_q),
    .hi_o (hi_o),
    .lo_o (lo_o)
  );

  assign wb_wd      = wb_wd_q;
  assign wb_wreg    = wb_wreg_q;
  assign wb_wdata   = wb_wdata_q;
  assign wb_hi      = wb_hi_q;
  assign wb_lo      = wb_lo_q;
  assign wb_whilo   = wb_whilo_q;
  assign wb_valid   = wb_valid_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb.sv
// Bench for mem_wb: instruction-level model plus directed vectors.
// Model compared every falling edge; literals pin key points.
module tb_mem_wb;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        mem_valid;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        wb_whilo;
  logic        wb_valid;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] retire_cnt;

  int total = 0;
  int bad   = 0;
  logic started = 1'b0;

  mem_wb dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .mem_valid  (mem_valid),
    .mem_wd     (mem_wd),
    .mem_wreg   (mem_wreg),
    .mem_wdata  (mem_wdata),
    .mem_hi     (mem_hi),
    .mem_lo     (mem_lo),
    .mem_whilo  (mem_whilo),
    .wb_wd      (wb_wd),
    .wb_wreg    (wb_wreg),
    .wb_wdata   (wb_wdata),
    .wb_hi      (wb_hi),
    .wb_lo      (wb_lo),
    .wb_whilo   (wb_whilo),
    .wb_valid   (wb_valid),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction as seen by the architecture.
  typedef struct packed {
    logic        v;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
  } ins_t;

  ins_t        m_wb;
  ins_t        m_in;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] m_cnt;

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Model: reset wipes everything instantly.
  always @(negedge rst) begin
    m_wb  = '0;
    m_hi  = '0;
    m_lo  = '0;
    m_cnt = '0;
  end

  // Model: retire the slot occupant, then decide what enters the slot.
  always @(posedge clk) begin
    if (rst) begin
      m_in = {mem_valid, mem_wd, mem_wreg, mem_wdata,
              mem_hi, mem_lo, mem_whilo};
      if (m_wb.v && !stall[5]) begin
        m_cnt = m_cnt + 1;
        if (m_wb.whilo) begin
          m_hi = m_wb.hi;
          m_lo = m_wb.lo;
        end
      end
      if (flush)
        m_wb = '0;
      else if (stall[4] && !stall[5])
        m_wb = '0;
      else if (!stall[4])
        m_wb = m_in;
    end
  end

  // Compare every output against the model each falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("m_wd",    32'(wb_wd),    32'(m_wb.wd));
      chk("m_wreg",  32'(wb_wreg),  32'(m_wb.wreg));
      chk("m_wdata", wb_wdata,      m_wb.wdata);
      chk("m_whi",   wb_hi,         m_wb.hi);
      chk("m_wlo",   wb_lo,         m_wb.lo);
      chk("m_whilo", 32'(wb_whilo), 32'(m_wb.whilo));
      chk("m_valid", 32'(wb_valid), 32'(m_wb.v));
      chk("m_hi",    hi_o,          m_hi);
      chk("m_lo",    lo_o,          m_lo);
      chk("m_cnt",   retire_cnt,    m_cnt);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic put(logic v, logic [4:0] wd, logic wreg,
                     logic [31:0] wdata, logic [31:0] hi,
                     logic [31:0] lo, logic whilo);
    mem_valid = v;
    mem_wd    = wd;
    mem_wreg  = wreg;
    mem_wdata = wdata;
    mem_hi    = hi;
    mem_lo    = lo;
    mem_whilo = whilo;
  endtask

  task automatic idle();
    put(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    stall = '0;
    flush = 1'b0;
    idle();
    rst = 1'b1;
    #1 rst = 1'b0;
    started = 1'b1;
    repeat (2) cyc();
    chk("rst_valid", 32'(wb_valid), 32'h0);
    chk("rst_cnt",   retire_cnt,    32'h0);
    chk("rst_hi",    hi_o,          32'h0);
    rst = 1'b1;

    // Plain load then commit.
    put(1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0);
    cyc();
    chk("a_wd",    32'(wb_wd),    32'h5);
    chk("a_wdata", wb_wdata,      32'hDEADBEEF);
    chk("a_valid", 32'(wb_valid), 32'h1);
    chk("a_cnt0",  retire_cnt,    32'h0);
    idle();
    cyc();
    chk("a_cnt1",  retire_cnt,    32'h1);

    // HI/LO write reaches hi_o/lo_o two edges after mem.
    put(1'b1, 5'd1, 1'b0, 32'h1, 32'h1234, 32'h5678, 1'b1);
    cyc();
    chk("b_whi",   wb_hi,         32'h1234);
    chk("b_hi0",   hi_o,          32'h0);
    put(1'b1, 5'd2, 1'b1, 32'h2, 32'hAAAA, 32'hBBBB, 1'b0);
    cyc();
    chk("b_hi",    hi_o,          32'h1234);
    chk("b_lo",    lo_o,          32'h5678);
    chk("b_cnt",   retire_cnt,    32'h2);
    put(1'b1, 5'd3, 1'b1, 32'h3, 32'hCCCC, 32'hDDDD, 1'b0);
    cyc();
    chk("b_hi2",   hi_o,          32'h1234);
    chk("b_cnt2",  retire_cnt,    32'h3);

    // mem stalled, wb running: bubbles, counter frozen after drain.
    put(1'b1, 5'd4, 1'b1, 32'h4, 32'h0, 32'h0, 1'b0);
    stall = 6'b011111;
    repeat (3) cyc();
    chk("c_valid", 32'(wb_valid), 32'h0);
    chk("c_cnt",   retire_cnt,    32'h4);
    stall = 6'b111111;
    repeat (2) cyc();
    chk("c_hold",  32'(wb_valid), 32'h0);
    chk("c_cnt2",  retire_cnt,    32'h4);
    chk("c_hi",    hi_o,          32'h1234);

    // stall[4]=0 with stall[5]=1 loads normally.
    put(1'b1, 5'd3, 1'b1, 32'h33, 32'h0, 32'h0, 1'b0);
    stall = 6'b100000;
    cyc();
    chk("d_valid", 32'(wb_valid), 32'h1);
    chk("d_wd",    32'(wb_wd),    32'h3);
    stall = 6'b000000;
    idle();
    cyc();
    chk("d_cnt",   retire_cnt,    32'h5);

    // Flush kills the incoming one but the wb one still commits.
    put(1'b1, 5'd6, 1'b0, 32'h6, 32'hCAFE, 32'hF00D, 1'b1);
    cyc();
    put(1'b1, 5'd7, 1'b1, 32'h7, 32'h1111, 32'h2222, 1'b1);
    flush = 1'b1;
    cyc();
    chk("e_hi",    hi_o,          32'hCAFE);
    chk("e_lo",    lo_o,          32'hF00D);
    chk("e_cnt",   retire_cnt,    32'h6);
    chk("e_valid", 32'(wb_valid), 32'h0);
    chk("e_whi",   wb_hi,         32'h0);
    flush = 1'b0;
    idle();
    cyc();

    // Counter wrap from all-ones.
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt_q;
    put(1'b1, 5'd8, 1'b1, 32'h8, 32'h0, 32'h0, 1'b0);
    cyc();
    chk("f_cnt",   retire_cnt,    32'hFFFF_FFFF);
    idle();
    cyc();
    chk("f_wrap",  retire_cnt,    32'h0);

    // Asynchronous reset with a valid instruction pending.
    put(1'b1, 5'd7, 1'b1, 32'h77, 32'h5555, 32'h6666, 1'b1);
    cyc();
    chk("g_pre",   32'(wb_valid), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("g_valid", 32'(wb_valid), 32'h0);
    chk("g_wd",    32'(wb_wd),    32'h0);
    chk("g_wdata", wb_wdata,      32'h0);
    chk("g_whi",   wb_hi,         32'h0);
    chk("g_hi",    hi_o,          32'h0);
    chk("g_lo",    lo_o,          32'h0);
    chk("g_cnt",   retire_cnt,    32'h0);
    cyc();
    rst = 1'b1;
    put(1'b1, 5'd9, 1'b1, 32'h99, 32'h0, 32'h0, 1'b0);
    cyc();
    chk("h_valid", 32'(wb_valid), 32'h1);
    chk("h_wd",    32'(wb_wd),    32'h9);
    chk("h_cnt",   retire_cnt,    32'h0);
    chk("h_hi",    hi_o,          32'h0);
    idle();
    cyc();
    chk("h_cnt1",  retire_cnt,    32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
